// File: rtl/stream_comparator.sv
// Two-stage valid/ready pipeline that compares operand pairs (signed or unsigned),
// emits a one-hot A>B / A==B / A<B result and keeps saturating per-result counters.
module stream_comparator #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iValid,
  output logic               oReady,
  input  logic [WIDTH-1:0]   iDataA,
  input  logic [WIDTH-1:0]   iDataB,
  input  logic               iSigned,
  input  logic               iClear,
  output logic               oValid,
  input  logic               iReady,
  output logic [2:0]         oData,
  output logic [COUNT_W-1:0] oGtCount,
  output logic [COUNT_W-1:0] oEqCount,
  output logic [COUNT_W-1:0] oLtCount
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  logic             adv;
  logic             deliver;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_signed;
  logic             s2_valid;
  logic [2:0]       s2_result;
  logic [WIDTH-1:0] key_a;
  logic [WIDTH-1:0] key_b;
  logic [2:0]       cmp_result;

  assign adv     = !s2_valid || iReady;
  assign oReady  = adv;
  assign deliver = s2_valid && iReady;
  assign oValid  = s2_valid;
  assign oData   = s2_valid ? s2_result : 3'b000;

  // Inverting the sign bit maps two's-complement ordering onto unsigned ordering.
  always_comb begin
    key_a            = s1_a;
    key_b            = s1_b;
    key_a[WIDTH-1]   = s1_a[WIDTH-1] ^ s1_signed;
    key_b[WIDTH-1]   = s1_b[WIDTH-1] ^ s1_signed;
    cmp_result       = 3'b100;
    if (key_a > key_b) begin
      cmp_result = 3'b001;
    end else if (key_a == key_b) begin
      cmp_result = 3'b010;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_signed <= 1'b0;
    end else if (adv) begin
      s1_valid <= iValid;
      if (iValid) begin
        s1_a      <= iDataA;
        s1_b      <= iDataB;
        s1_signed <= iSigned;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      s2_valid  <= 1'b0;
      s2_result <= 3'b000;
    end else if (adv) begin
      s2_valid  <= s1_valid;
      s2_result <= s1_valid ? cmp_result : 3'b000;
    end
  end

  // Clear beats a same-cycle delivery; counters stick at all-ones.
  always_ff @(posedge iClk) begin
    if (iRst || iClear) begin
      oGtCount <= '0;
      oEqCount <= '0;
      oLtCount <= '0;
    end else if (deliver) begin
      if (s2_result[0] && (oGtCount != CNT_MAX)) oGtCount <= oGtCount + CNT_ONE;
      if (s2_result[1] && (oEqCount != CNT_MAX)) oEqCount <= oEqCount + CNT_ONE;
      if (s2_result[2] && (oLtCount != CNT_MAX)) oLtCount <= oLtCount + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_stream_comparator.sv
// Self-checking bench: an 8-bit instance driven by directed vectors and a 32-bit
// instance driven randomly, both checked every cycle against a transaction model.
module tb_stream_comparator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst8, v8, s8, c8, rdy8, ordy8, ov8;
  logic [7:0] a8, b8;
  logic [2:0] od8;
  logic [3:0] gt8, eq8, lt8;

  logic        rst32, v32, s32, c32, rdy32, ordy32, ov32;
  logic [31:0] a32, b32;
  logic [2:0]  od32;
  logic [15:0] gt32, eq32, lt32;

  stream_comparator #(.WIDTH(8), .COUNT_W(4)) dut8 (
    .iClk(clk), .iRst(rst8), .iValid(v8), .oReady(ordy8), .iDataA(a8), .iDataB(b8),
    .iSigned(s8), .iClear(c8), .oValid(ov8), .iReady(rdy8), .oData(od8),
    .oGtCount(gt8), .oEqCount(eq8), .oLtCount(lt8)
  );

  stream_comparator #(.WIDTH(32), .COUNT_W(16)) dut32 (
    .iClk(clk), .iRst(rst32), .iValid(v32), .oReady(ordy32), .iDataA(a32), .iDataB(b32),
    .iSigned(s32), .iClear(c32), .oValid(ov32), .iReady(rdy32), .oData(od32),
    .oGtCount(gt32), .oEqCount(eq32), .oLtCount(lt32)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference ordering computed on plain integers after sign extension.
  function automatic bit [2:0] refCmp(input logic [63:0] a, input logic [63:0] b, input logic sgn, input int w);
    longint sa, sbv;
    sa  = longint'(a);
    sbv = longint'(b);
    if (sgn && a >= (64'd1 << (w - 1))) sa = sa - (longint'(1) << w);
    if (sgn && b >= (64'd1 << (w - 1))) sbv = sbv - (longint'(1) << w);
    if (sa > sbv) return 3'b001;
    if (sa == sbv) return 3'b010;
    return 3'b100;
  endfunction

  bit              armed[2];
  bit              p0v[2], p1v[2];
  bit [2:0]        p0r[2], p1r[2];
  longint unsigned mGt[2], mEq[2], mLt[2], deliv[2];
  bit [2:0]        sb0[$], sb1[$];

  task automatic modelCycle(input int k, input int w, input int cw,
                            input logic rst, input logic iv, input logic ir, input logic is, input logic ic,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic ov, input logic [2:0] od, input logic ordy,
                            input logic [63:0] gt, input logic [63:0] eq, input logic [63:0] lt);
    string tag;
    longint unsigned cmax;
    bit [2:0] front;
    int depth;
    tag  = (k == 1) ? "w32" : "w8";
    cmax = (64'd1 << cw) - 1;
    if (armed[k]) begin
      checkOutput({tag, " oValid"}, 64'(ov), 64'(p1v[k]));
      checkOutput({tag, " oData"}, 64'(od), 64'(p1v[k] ? p1r[k] : 3'b000));
      checkOutput({tag, " oReady"}, 64'(ordy), 64'(!p1v[k] || ir));
      checkOutput({tag, " gtCount"}, gt, mGt[k]);
      checkOutput({tag, " eqCount"}, eq, mEq[k]);
      checkOutput({tag, " ltCount"}, lt, mLt[k]);
      if (ov === 1'b1) checkOutput({tag, " onehot"}, 64'($countones(od)), 64'd1);
    end
    if (rst) begin
      armed[k] = 1'b1;
      p0v[k] = 1'b0; p1v[k] = 1'b0;
      mGt[k] = 0; mEq[k] = 0; mLt[k] = 0; deliv[k] = 0;
      if (k == 1) sb1.delete(); else sb0.delete();
    end else if (armed[k]) begin
      if (p1v[k] && ir) begin
        depth = (k == 1) ? sb1.size() : sb0.size();
        checks++;
        if (depth == 0) begin
          errors++;
          $display("[TB] FAIL %s order: delivery with no pending pair at %0t", tag, $time);
        end else begin
          front = (k == 1) ? sb1.pop_front() : sb0.pop_front();
          checkOutput({tag, " order"}, 64'(od), 64'(front));
        end
        deliv[k]++;
        if (p1r[k] == 3'b001 && mGt[k] < cmax) mGt[k]++;
        if (p1r[k] == 3'b010 && mEq[k] < cmax) mEq[k]++;
        if (p1r[k] == 3'b100 && mLt[k] < cmax) mLt[k]++;
      end
      if (ic) begin
        mGt[k] = 0; mEq[k] = 0; mLt[k] = 0; deliv[k] = 0;
      end
      if (!p1v[k] || ir) begin
        p1v[k] = p0v[k];
        p1r[k] = p0r[k];
        p0v[k] = iv;
        p0r[k] = refCmp(a, b, is, w);
        if (iv) begin
          if (k == 1) sb1.push_back(p0r[k]); else sb0.push_back(p0r[k]);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    modelCycle(0, 8, 4, rst8, v8, rdy8, s8, c8, 64'(a8), 64'(b8), ov8, od8, ordy8,
               64'(gt8), 64'(eq8), 64'(lt8));
    modelCycle(1, 32, 16, rst32, v32, rdy32, s32, c32, 64'(a32), 64'(b32), ov32, od32, ordy32,
               64'(gt32), 64'(eq32), 64'(lt32));
  end

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b, input logic s,
                               input logic rdy, input logic clr, input logic rst);
    @(posedge clk);
    #1;
    v8 = v; a8 = a; b8 = b; s8 = s; rdy8 = rdy; c8 = clr; rst8 = rst;
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [7:0] bpA[4] = '{8'd5, 8'd9, 8'd4, 8'd1};
  logic [7:0] bpB[4] = '{8'd9, 8'd5, 8'd4, 8'd2};
  logic [2:0] bpExp[4] = '{3'b100, 3'b001, 3'b010, 3'b100};
  logic [2:0] got[$];
  int idx;

  initial begin
    rst8 = 1; v8 = 0; s8 = 0; c8 = 0; rdy8 = 1; a8 = 0; b8 = 0;
    rst32 = 1; v32 = 0; s32 = 0; c32 = 0; rdy32 = 1; a32 = 0; b32 = 0;
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    rst32 = 0;

    // Unsigned stream (200,100), (7,7), (3,9).
    applyStimulus(1, 8'd200, 8'd100, 0, 1, 0, 0);
    checkOutput("reset oValid", 64'(ov8), 64'd0);
    checkOutput("reset oData", 64'(od8), 64'd0);
    checkOutput("reset oReady", 64'(ordy8), 64'd1);
    checkOutput("reset counters", {52'd0, gt8, eq8, lt8}, 64'd0);
    applyStimulus(1, 8'd7, 8'd7, 0, 1, 0, 0);
    applyStimulus(1, 8'd3, 8'd9, 0, 1, 0, 0);
    checkOutput("unsigned 200>100", 64'(od8), 64'(3'b001));
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("unsigned 7==7", 64'(od8), 64'(3'b010));
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("unsigned 3<9", 64'(od8), 64'(3'b100));
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("unsigned drained", 64'(ov8), 64'd0);
    checkOutput("unsigned counts", {52'd0, gt8, eq8, lt8}, 64'h111);

    // 0x80 vs 0x01 in both modes.
    applyStimulus(1, 8'h80, 8'h01, 1, 1, 0, 0);
    applyStimulus(1, 8'h80, 8'h01, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("signed 0x80<0x01", 64'(od8), 64'(3'b100));
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("unsigned 0x80>0x01", 64'(od8), 64'(3'b001));
    applyStimulus(0, 0, 0, 0, 1, 0, 0);

    // Backpressure: downstream stalls in cycles 3..6.
    idx = 0;
    got.delete();
    for (int cyc = 1; cyc <= 16; cyc++) begin
      int p;
      p = (idx < 4) ? idx : 3;
      applyStimulus(idx < 4, bpA[p], bpB[p], 0, (cyc >= 3 && cyc <= 6) ? 1'b0 : 1'b1, 0, 0);
      if (cyc >= 3 && cyc <= 6) begin
        checkOutput("bp oReady stalled", 64'(ordy8), 64'd0);
        checkOutput("bp oData stable", 64'(od8), 64'(3'b100));
      end
      if (ov8 && rdy8) got.push_back(od8);
      if (v8 && ordy8) idx++;
    end
    checkOutput("bp accepted", 64'(idx), 64'd4);
    checkOutput("bp delivered", 64'(got.size()), 64'd4);
    for (int i = 0; i < got.size() && i < 4; i++) checkOutput("bp in order", 64'(got[i]), 64'(bpExp[i]));
    checkOutput("bp nothing pending", 64'(sb0.size()), 64'd0);

    // Saturation, then clear colliding with an A==B delivery.
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 17; i++) applyStimulus(1, 8'd10, 8'd3, 0, 1, 0, 0);
    applyStimulus(1, 8'd6, 8'd6, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkOutput("saturated gtCount", 64'(gt8), 64'hF);
    checkOutput("eq delivered with clear", 64'(od8), 64'(3'b010));
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("clear wins counters", {52'd0, gt8, eq8, lt8}, 64'd0);

    // Reset while a pair is in flight and another is being offered.
    applyStimulus(1, 8'd9, 8'd1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("pre-reset gtCount", 64'(gt8), 64'd1);
    applyStimulus(1, 8'd1, 8'd2, 0, 1, 0, 0);
    applyStimulus(1, 8'd2, 8'd2, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("flushed oValid", 64'(ov8), 64'd0);
      checkOutput("flushed oReady", 64'(ordy8), 64'd1);
      checkOutput("flushed counters", {52'd0, gt8, eq8, lt8}, 64'd0);
    end

    // Random regression on the 32-bit instance.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      v32   = ($urandom % 4) != 0;
      rdy32 = ($urandom % 4) != 0;
      s32   = $urandom % 2;
      a32   = $urandom;
      case ($urandom % 3)
        0:       b32 = a32;
        1:       b32 = a32 ^ (32'd1 << ($urandom % 32));
        default: b32 = $urandom;
      endcase
      c32   = ($urandom % 500) == 0;
    end
    @(posedge clk);
    #1;
    v32 = 0; rdy32 = 1; c32 = 0;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("w32 drained", 64'(sb1.size()), 64'd0);
    checkOutput("w32 counter sum", 64'(gt32) + 64'(eq32) + 64'(lt32), deliv[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
